// File: rtl/mc_if_pkg.sv
// ---------------------------------------------------------------------------
// mc_if_pkg
// Shared types and helpers for the external-memory pin interface:
//   - arb_state_e : shared-bus arbitration states
//   - strobes_t   : bundle of the active-low registered pin strobes
//   - STROBES_OFF : inactive (all ones) value for that bundle
//   - cnt_w()     : counter width for a 0..n counter, never below 1 bit
// ---------------------------------------------------------------------------
package mc_if_pkg;

   typedef enum logic [1:0] {
      OWN     = 2'd0,
      DRAIN   = 2'd1,
      REL     = 2'd2,
      RECLAIM = 2'd3
   } arb_state_e;

   typedef struct packed {
      logic oe_;
      logic we_;
      logic cas_;
      logic ras_;
      logic adsc_;
      logic adv_;
   } strobes_t;

   localparam strobes_t STROBES_OFF = '{default: 1'b1};

   // Width of a counter holding 0..n. A zero-valued limit still gets one
   // bit so the register stays declarable; it simply never leaves 0.
   function automatic int cnt_w(input int n);
      int w;
      w = $clog2(n + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/mc_mem_if_arb_if.sv
// ---------------------------------------------------------------------------
// mc_mem_if_arb_if
// Pad-side bundle of the external memory bus.
//   master : the pin interface block (drives address/data/strobes/grant,
//            samples data, parity, ack, status and bus request)
//   slave  : the pads / external memory model
// ---------------------------------------------------------------------------
interface mc_mem_if_arb_if #(
   parameter int DW   = 32,
   parameter int PW   = DW / 8,
   parameter int AW   = 24,
   parameter int CS_N = 8
) ();

   // pad inputs
   logic            mc_br;
   logic            mc_ack;
   logic            mc_sts_i;
   logic [DW-1:0]   mc_data_i;
   logic [PW-1:0]   mc_dp_i;

   // pad outputs
   logic            mc_bg;
   logic [AW-1:0]   mc_addr;
   logic [DW-1:0]   mc_data_o;
   logic [PW-1:0]   mc_dp_o;
   logic            mc_data_oe;
   logic [PW-1:0]   mc_dqm;
   logic            mc_oe_;
   logic            mc_we_;
   logic            mc_cas_;
   logic            mc_ras_;
   logic            mc_cke_;
   logic            mc_adsc_;
   logic            mc_adv_;
   logic [CS_N-1:0] mc_cs_;
   logic            mc_rp;
   logic            mc_c_oe;
   logic            mc_zz_o;

   modport master (
      input  mc_br, mc_ack, mc_sts_i, mc_data_i, mc_dp_i,
      output mc_bg, mc_addr, mc_data_o, mc_dp_o, mc_data_oe, mc_dqm,
             mc_oe_, mc_we_, mc_cas_, mc_ras_, mc_cke_, mc_adsc_, mc_adv_,
             mc_cs_, mc_rp, mc_c_oe, mc_zz_o
   );

   modport slave (
      output mc_br, mc_ack, mc_sts_i, mc_data_i, mc_dp_i,
      input  mc_bg, mc_addr, mc_data_o, mc_dp_o, mc_data_oe, mc_dqm,
             mc_oe_, mc_we_, mc_cas_, mc_ras_, mc_cke_, mc_adsc_, mc_adv_,
             mc_cs_, mc_rp, mc_c_oe, mc_zz_o
   );

endinterface

// File: rtl/mc_bus_arb.sv
// ---------------------------------------------------------------------------
// mc_bus_arb
// Shared-bus request/grant FSM. The controller keeps the bus (OWN) until an
// external master requests it while the controller is idle; the bus is then
// drained for one cycle, granted (REL) for as long as the request stays up,
// and reclaimed with one dead cycle before the controller owns it again.
// Ports:
//   mc_clk, rst : clock, synchronous active-high reset
//   br_r        : registered external bus request
//   bus_idle    : controller has nothing in flight
//   own         : 1 in OWN (pin drivers enabled)
//   bus_rel     : 1 in every state except OWN
//   mc_bg       : registered bus grant, 1 while in REL
// ---------------------------------------------------------------------------
module mc_bus_arb
   import mc_if_pkg::*;
(
   input  logic mc_clk,
   input  logic rst,
   input  logic br_r,
   input  logic bus_idle,
   output logic own,
   output logic bus_rel,
   output logic mc_bg
);

   arb_state_e state_q, state_d;
   logic       mc_bg_q, mc_bg_d;

   always_ff @(posedge mc_clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q <= OWN;
         mc_bg_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mc_bg_q <= mc_bg_d;
      end
   end

   always_comb begin
      // NOTE: defaults first, so no branch can leave an output unassigned.
      state_d = state_q;
      unique case (state_q)
         OWN:     if (br_r && bus_idle) state_d = DRAIN;
         DRAIN:   state_d = br_r ? REL : RECLAIM;
         REL:     if (!br_r) state_d = RECLAIM;
         RECLAIM: state_d = OWN;
         default: state_d = OWN;
      endcase
      // Grant is registered off the next state so the pin is glitch-free
      // yet still tracks the REL state cycle for cycle.
      mc_bg_d = (state_d == REL);
   end

   assign own     = (state_q == OWN);
   assign bus_rel = (state_q != OWN);
   assign mc_bg   = mc_bg_q;

endmodule

// File: rtl/mc_mem_if_arb.sv
// ---------------------------------------------------------------------------
// mc_mem_if_arb
// External-memory pin interface. Registers every controller command,
// address and data towards the pads (except cke_, which passes straight
// through), captures pad inputs every cycle, and adds:
//   - shared-bus arbitration (mc_bus_arb) that forces the pins inactive
//     whenever the bus is not owned,
//   - read-to-write turnaround: data drive is held off TURN_CYC cycles
//     after the registered output enable mc_oe_ was last low,
//   - delayed sleep: mc_zz_o rises after ZZ_DLY consecutive suspended cycles.
// Ports:
//   mc_clk, rst            : clock, synchronous active-high reset
//   controller inputs      : cs/strobe/address/data/byte-enable sources
//   bus_rel, turn_stall    : back-pressure to the controller
//   mc_sts_ir, mc_ack_r,
//   mc_br_r, mc_data_ir    : registered pad captures
//   pin                    : pad bundle (master side)
// ---------------------------------------------------------------------------
module mc_mem_if_arb
   import mc_if_pkg::*;
#(
   parameter int DW       = 32,
   parameter int PW       = DW / 8,
   parameter int AW       = 24,
   parameter int CS_N     = 8,
   parameter int TURN_CYC = 1,
   parameter int ZZ_DLY   = 4
) (
   input  logic             mc_clk,
   input  logic             rst,

   input  logic             cs_en,
   input  logic             rfr_ack,
   input  logic             lmr_sel,
   input  logic             susp_sel,
   input  logic             suspended_o,
   input  logic             fs,
   input  logic [CS_N-1:0]  cs,
   input  logic [CS_N-1:0]  cs_need_rfr,
   input  logic [CS_N-1:0]  spec_req_cs,
   input  logic             we_,
   input  logic             ras_,
   input  logic             cas_,
   input  logic             oe_,
   input  logic             cke_,
   input  logic             adsc_d,
   input  logic             adv_d,
   input  logic             c_oe_d,
   input  logic             data_oe,
   input  logic [AW-1:0]    addr_d,
   input  logic [DW-1:0]    data_od,
   input  logic [PW-1:0]    dp_od,
   input  logic [PW-1:0]    byte_en,
   input  logic             byte_en_vld,
   input  logic             wb_cycle,
   input  logic             wr_cycle,
   input  logic             bus_idle,

   output logic             bus_rel,
   output logic             turn_stall,
   output logic             mc_sts_ir,
   output logic             mc_ack_r,
   output logic             mc_br_r,
   output logic [DW+PW-1:0] mc_data_ir,

   mc_mem_if_arb_if.master  pin
);

   localparam int TW = cnt_w(TURN_CYC);
   localparam int ZW = cnt_w(ZZ_DLY);

   logic              own;
   logic [CS_N-1:0]   sel;

   logic [AW-1:0]     mc_addr_q,    mc_addr_d;
   logic [DW-1:0]     mc_data_o_q,  mc_data_o_d;
   logic [PW-1:0]     mc_dp_o_q,    mc_dp_o_d;
   logic              mc_data_oe_q, mc_data_oe_d;
   logic [PW-1:0]     mc_dqm_q,     mc_dqm_d;
   strobes_t          strb_q,       strb_d;
   logic [CS_N-1:0]   mc_cs_q,      mc_cs_d;
   logic              mc_rp_q,      mc_rp_d;
   logic              mc_c_oe_q,    mc_c_oe_d;
   logic              mc_zz_q,      mc_zz_d;
   logic              mc_sts_ir_q,  mc_sts_ir_d;
   logic              mc_ack_r_q,   mc_ack_r_d;
   logic              mc_br_r_q,    mc_br_r_d;
   logic [DW+PW-1:0]  mc_data_ir_q, mc_data_ir_d;
   logic [PW-1:0]     be_r_q,       be_r_d;
   logic [TW-1:0]     tcnt_q,       tcnt_d;
   logic [ZW-1:0]     zcnt_q,       zcnt_d;

   mc_bus_arb u_arb (
      .mc_clk   (mc_clk),
      .rst      (rst),
      .br_r     (mc_br_r_q),
      .bus_idle (bus_idle),
      .own      (own),
      .bus_rel  (bus_rel),
      .mc_bg    (pin.mc_bg)
   );

   always_comb begin
      // Refresh/suspend selects win over LMR, which wins over normal access.
      sel = cs;
      if (rfr_ack | susp_sel) sel = cs_need_rfr;
      else if (lmr_sel)       sel = spec_req_cs;

      // Defaults: pins parked inactive, data path holding.
      mc_addr_d    = mc_addr_q;
      mc_data_o_d  = mc_data_o_q;
      mc_dp_o_d    = mc_dp_o_q;
      strb_d       = STROBES_OFF;
      mc_cs_d      = '1;
      mc_dqm_d     = '1;
      mc_data_oe_d = 1'b0;

      if (own) begin
         mc_addr_d     = addr_d;
         mc_data_o_d   = data_od;
         mc_dp_o_d     = dp_od;
         strb_d.oe_    = oe_ | susp_sel;
         strb_d.we_    = we_;
         strb_d.cas_   = cas_;
         strb_d.ras_   = ras_;
         strb_d.adsc_  = ~adsc_d;
         strb_d.adv_   = ~adv_d;
         mc_cs_d       = ~({CS_N{cs_en}} & sel);
         if (susp_sel)                  mc_dqm_d = '1;
         else if (data_oe)              mc_dqm_d = ~be_r_q;
         else if (wb_cycle & ~wr_cycle) mc_dqm_d = '0;
         else                           mc_dqm_d = '1;
         mc_data_oe_d  = data_oe & ~susp_sel & c_oe_d & (tcnt_q == '0);
      end

      be_r_d = byte_en_vld ? byte_en : be_r_q;

      // Turnaround counter re-arms while the pads are still being read
      // (registered mc_oe_ low) and bleeds down once they are released.
      if (!strb_q.oe_)        tcnt_d = TW'(TURN_CYC);
      else if (tcnt_q != '0)  tcnt_d = tcnt_q - 1'b1;
      else                    tcnt_d = tcnt_q;

      if (!suspended_o)                zcnt_d = '0;
      else if (zcnt_q != ZW'(ZZ_DLY))  zcnt_d = zcnt_q + 1'b1;
      else                             zcnt_d = zcnt_q;
      mc_zz_d = suspended_o & (zcnt_q == ZW'(ZZ_DLY));

      mc_rp_d      = ~suspended_o & ~fs;
      mc_c_oe_d    = c_oe_d;
      mc_sts_ir_d  = pin.mc_sts_i;
      mc_ack_r_d   = pin.mc_ack;
      mc_br_r_d    = pin.mc_br;
      mc_data_ir_d = {pin.mc_dp_i, pin.mc_data_i};
   end

   always_ff @(posedge mc_clk) begin
      if (rst) begin
         mc_addr_q    <= '0;
         mc_data_o_q  <= '0;
         mc_dp_o_q    <= '0;
         mc_data_oe_q <= 1'b0;
         mc_dqm_q     <= '1;
         strb_q       <= STROBES_OFF;
         mc_cs_q      <= '1;
         mc_rp_q      <= 1'b0;
         mc_c_oe_q    <= 1'b0;
         mc_zz_q      <= 1'b0;
         mc_sts_ir_q  <= 1'b0;
         mc_ack_r_q   <= 1'b0;
         mc_br_r_q    <= 1'b0;
         mc_data_ir_q <= '0;
         be_r_q       <= '0;
         tcnt_q       <= '0;
         zcnt_q       <= '0;
      end else begin
         mc_addr_q    <= mc_addr_d;
         mc_data_o_q  <= mc_data_o_d;
         mc_dp_o_q    <= mc_dp_o_d;
         mc_data_oe_q <= mc_data_oe_d;
         mc_dqm_q     <= mc_dqm_d;
         strb_q       <= strb_d;
         mc_cs_q      <= mc_cs_d;
         mc_rp_q      <= mc_rp_d;
         mc_c_oe_q    <= mc_c_oe_d;
         mc_zz_q      <= mc_zz_d;
         mc_sts_ir_q  <= mc_sts_ir_d;
         mc_ack_r_q   <= mc_ack_r_d;
         mc_br_r_q    <= mc_br_r_d;
         mc_data_ir_q <= mc_data_ir_d;
         be_r_q       <= be_r_d;
         tcnt_q       <= tcnt_d;
         zcnt_q       <= zcnt_d;
      end
   end

   assign turn_stall = data_oe & (tcnt_q != '0);

   assign pin.mc_addr    = mc_addr_q;
   assign pin.mc_data_o  = mc_data_o_q;
   assign pin.mc_dp_o    = mc_dp_o_q;
   assign pin.mc_data_oe = mc_data_oe_q;
   assign pin.mc_dqm     = mc_dqm_q;
   assign pin.mc_oe_     = strb_q.oe_;
   assign pin.mc_we_     = strb_q.we_;
   assign pin.mc_cas_    = strb_q.cas_;
   assign pin.mc_ras_    = strb_q.ras_;
   assign pin.mc_adsc_   = strb_q.adsc_;
   assign pin.mc_adv_    = strb_q.adv_;
   assign pin.mc_cke_    = cke_;
   assign pin.mc_cs_     = mc_cs_q;
   assign pin.mc_rp      = mc_rp_q;
   assign pin.mc_c_oe    = mc_c_oe_q;
   assign pin.mc_zz_o    = mc_zz_q;

   assign mc_sts_ir  = mc_sts_ir_q;
   assign mc_ack_r   = mc_ack_r_q;
   assign mc_br_r    = mc_br_r_q;
   assign mc_data_ir = mc_data_ir_q;

endmodule
